sync_fifo_ctrl: RTL
===================

Name: sync_fifo_ctrl

Overview:
Parametrised single-clock FIFO, next generation of the team's valid/grant FIFO. Adds:
- arbitrary (non-power-of-2) depth
- occupancy count output
- programmable almost-full / almost-empty flags
- synchronous flush
- sticky overflow/underflow error flags

Sits between streaming producers/consumers in the datapath. Storage is an internal flop array with combinational read, so data at the head is presented in the same cycle as pop_valid_o (first-word-fall-through).

Parameters:
DATA_WIDTH, 8, width of each entry in bits (>=1)
DEPTH, 4, number of entries (>=2, any integer, not restricted to powers of 2)
AFULL_THRESH, DEPTH-1, almost_full_o asserted when count >= AFULL_THRESH (1..DEPTH)
AEMPTY_THRESH, 1, almost_empty_o asserted when count <= AEMPTY_THRESH (0..DEPTH-1)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  reset, asynchronous, active-low
flush_i  in  1  synchronous flush: empties the FIFO at next edge
push_valid_i  in  1  producer has data
push_data_i  in  DATA_WIDTH  data to push
push_grant_o  out  1  FIFO accepts push this cycle
pop_valid_o  out  1  head entry available
pop_data_o  out  DATA_WIDTH  head entry data
pop_grant_i  in  1  consumer takes head entry
count_o  out  CW=$clog2(DEPTH+1)  current occupancy, 0..DEPTH
almost_full_o  out  1  count_o >= AFULL_THRESH
almost_empty_o  out  1  count_o <= AEMPTY_THRESH
overflow_o  out  1  sticky: push_valid_i seen while full
underflow_o  out  1  sticky: pop_grant_i seen while empty

Behaviour:
- Reset (reset_n low, async) sets the following. Memory contents are not reset.
  - wr_ptr = rd_ptr = count = 0; overflow_o = underflow_o = 0.
  - Resulting outputs: push_grant_o=1, pop_valid_o=0, count_o=0, almost_full_o=0, almost_empty_o=1 (for default thresholds).
- State is the count register (0..DEPTH), width CW.
  - full = (count==DEPTH); empty = (count==0).
  - Full/empty are never derived from pointer equality.
- push_grant_o = !full & !flush_i. pop_valid_o = !empty & !flush_i.
- Push fire = push_valid_i & push_grant_o.
  - Writes push_data_i to mem[wr_ptr] at the edge.
  - wr_ptr advances: DEPTH-1 wraps to 0.
- Pop fire = pop_valid_o & pop_grant_i.
  - rd_ptr advances with the same wrap rule.
  - pop_data_o = mem[rd_ptr] combinationally at all times; value is don't-care when empty.
- Count update:
  - +1 on push only; -1 on pop only.
  - Unchanged when both fire or neither fires.
- Latency: an entry pushed at edge N is visible on pop_data_o with pop_valid_o=1 in the cycle after edge N. Minimum 1 cycle, no bypass.
- Full: push_grant_o=0, even if pop fires in the same cycle. There is no full-cycle pass-through; push is accepted the cycle after the pop.
- Empty: pop_valid_o=0; a push in the same cycle is not forwarded.
- Simultaneous push+pop when 0<count<DEPTH: both fire, count holds, both pointers advance.
- Flush_i=1:
  - Grants and valids are forced to 0, so no transfer occurs that cycle.
  - At the edge: wr_ptr=rd_ptr=count=0.
  - Sticky error flags are also cleared.
  - Flush has priority over all other activity.
- Error flags:
  - overflow_o sets at the edge after a cycle with push_valid_i & full & !flush_i.
  - underflow_o sets at the edge after a cycle with pop_grant_i & empty & !flush_i.
  - Both hold until reset or flush.
  - Dropped pushes do not modify state.
- almost_full_o and almost_empty_o are combinational from the count register: no extra latency, glitch-free between edges.
- Reset mid-operation: all pointers, count and flags return to reset values immediately and asynchronously. Data in flight is lost.
- Elaboration: $error if DEPTH<2, AFULL_THRESH outside 1..DEPTH, or AEMPTY_THRESH outside 0..DEPTH-1.

Decomposition:
- Shared package fifo_pkg holds:
  - function ptr_inc(ptr, depth): wrap-aware increment
  - localparam helper for CW / address-width computation
- One sub-module, fifo_storage:
  - DATA_WIDTH x DEPTH flop array
  - 1 write port (sync, enable), 1 read port (combinational)
- Pointer, count, flag and handshake logic stay in sync_fifo_ctrl.

Test Plan:
- Reset then idle -> push_grant_o=1, pop_valid_o=0, count_o=0, almost_empty_o=1, overflow_o=0.
- DEPTH=5, push 0x11..0x15 back-to-back, then pop 5 with pop_grant_i=1 -> values:
  - count_o 1..5; push_grant_o=0 at count 5; almost_full_o at count>=4.
  - Pops return 0x11..0x15 in order; wr_ptr/rd_ptr wrap 4->0 on the next refill.
- Count=2, push and pop fire together for 10 cycles with incrementing data -> count_o stays 2; output order preserved, no loss or duplication.
- Full (count=4, DEPTH=4), push_valid_i=1 and pop_grant_i=1 same cycle -> pop fires, push not granted, count_o=3; push granted next cycle; overflow_o set.
- Count=3, assert flush_i with push_valid_i=1 and pop_grant_i=1 -> that cycle push_grant_o=pop_valid_o=0; next cycle count_o=0, pop_valid_o=0, error flags cleared.
- Empty, pop_grant_i=1 -> underflow_o=1 next cycle, count_o stays 0; deassert reset_n mid-stream at count=3 -> count_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO controller: width computation and pointer wrap.
package fifo_pkg;

    // Bits needed to hold an occupancy value in 0..depth.
    function automatic int unsigned calc_cw(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Bits needed to address depth entries (at least one bit).
    function automatic int unsigned calc_aw(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Wrap-aware increment: depth-1 rolls over to 0, so any depth works.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_storage.sv
// DATA_WIDTH x DEPTH flop array: one synchronous write port, one combinational read port.
module fifo_storage #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned AW         = 2
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port is combinational so the head is visible alongside pop_valid_o.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FWFT FIFO with arbitrary depth, occupancy count, threshold flags,
// synchronous flush and sticky overflow/underflow flags.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned AFULL_THRESH  = DEPTH - 1,
    parameter int unsigned AEMPTY_THRESH = 1,
    localparam int unsigned CW           = calc_cw(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush_i,
    input  logic                  push_valid_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    output logic                  push_grant_o,
    output logic                  pop_valid_o,
    output logic [DATA_WIDTH-1:0] pop_data_o,
    input  logic                  pop_grant_i,
    output logic [CW-1:0]         count_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int unsigned AW = calc_aw(DEPTH);

    // Reject illegal parameterisations at elaboration.
    if (DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo_ctrl: DEPTH must be >= 2");
    end
    if (AFULL_THRESH == 0 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("sync_fifo_ctrl: AFULL_THRESH must be in 1..DEPTH");
    end
    if (AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
        $error("sync_fifo_ctrl: AEMPTY_THRESH must be in 0..DEPTH-1");
    end

    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          full, empty;
    logic          push_fire, pop_fire;

    // Occupancy-derived status and handshake; flush blocks every transfer.
    always_comb begin
        full           = (count_q == CW'(DEPTH));
        empty          = (count_q == '0);
        push_grant_o   = !full && !flush_i;
        pop_valid_o    = !empty && !flush_i;
        push_fire      = push_valid_i && push_grant_o;
        pop_fire       = pop_valid_o && pop_grant_i;
        count_o        = count_q;
        almost_full_o  = (count_q >= CW'(AFULL_THRESH));
        almost_empty_o = (count_q <= CW'(AEMPTY_THRESH));
        overflow_o     = ovf_q;
        underflow_o    = unf_q;
    end

    // Next-state for pointers, count and sticky error flags.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (flush_i) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (push_fire) begin
                wr_ptr_d = AW'(ptr_inc(32'(wr_ptr_q), DEPTH));
            end
            if (pop_fire) begin
                rd_ptr_d = AW'(ptr_inc(32'(rd_ptr_q), DEPTH));
            end
            if (push_fire && !pop_fire) begin
                count_d = count_q + CW'(1);
            end else if (pop_fire && !push_fire) begin
                count_d = count_q - CW'(1);
            end
            if (push_valid_i && full) begin
                ovf_d = 1'b1;
            end
            if (pop_grant_i && empty) begin
                unf_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    fifo_storage #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_storage (
        .clk     (clk),
        .we_i    (push_fire),
        .waddr_i (wr_ptr_q),
        .wdata_i (push_data_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (pop_data_o)
    );

endmodule
